id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/minisys_pkg.sv | 21 ++
 rtl/pipe_skid_buf.sv | 100 ++++++++++
 rtl/id_ex_pipe.sv | 128 ++++++++++++
 tb/tb_id_ex_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// ============================================================================
// Module   : minisys_pkg
// Desc     : Shared pipeline types: occupancy encoding and NOP bubble constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package minisys_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    localparam logic [7:0] c_NOP_ALUOP  = 8'h00;
    localparam logic [2:0] c_NOP_ALUSEL = 3'b000;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module   : pipe_skid_buf
// Desc     : Two-entry (main + skid) valid/ready buffer with registered ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_buf
    import minisys_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;
    logic             r_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in;
    logic             w_out;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    assign w_in      = in_valid && r_ready;
    assign w_out     = (r_state != OCC_EMPTY) && out_ready;
    assign in_ready  = r_ready;
    assign out_valid = (r_state != OCC_EMPTY);
    assign out_data  = r_main;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // A handshake seen in the flush cycle is deliberately dropped.
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_in) begin
                        w_state_nxt = OCC_ONE;
                        w_load_main = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_in && w_out) begin
                        w_load_main = 1'b1;
                    end else if (w_in) begin
                        w_state_nxt = OCC_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out) begin
                        w_state_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_out) begin
                        w_state_nxt      = OCC_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OCC_EMPTY;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != OCC_TWO);
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe.sv
// ============================================================================
// Module   : id_ex_pipe
// Desc     : ID/EX pipeline register with skid buffering and delay-slot flag.
//            Optional exception payload enabled by macro ID_EX_EXCEPT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe
    import minisys_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ALUOP_W   = 8,
    parameter int ALUSEL_W  = 3,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic [ALUSEL_W-1:0]  id_alusel,
    input  logic [DATA_W-1:0]    id_reg1,
    input  logic [DATA_W-1:0]    id_reg2,
    input  logic [REGADDR_W-1:0] id_wd,
    input  logic                 id_wreg,
    input  logic [DATA_W-1:0]    id_link_address,
    input  logic [DATA_W-1:0]    id_inst,
    input  logic                 id_is_in_delayslot,
    input  logic                 id_next_inst_in_delayslot,
`ifdef ID_EX_EXCEPT_EN
    input  logic [31:0]          id_excepttype,
    input  logic [DATA_W-1:0]    id_current_inst_address,
    output logic [31:0]          ex_excepttype,
    output logic [DATA_W-1:0]    ex_current_inst_address,
`endif
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [ALUSEL_W-1:0]  ex_alusel,
    output logic [DATA_W-1:0]    ex_reg1,
    output logic [DATA_W-1:0]    ex_reg2,
    output logic [REGADDR_W-1:0] ex_wd,
    output logic                 ex_wreg,
    output logic [DATA_W-1:0]    ex_link_address,
    output logic [DATA_W-1:0]    ex_inst,
    output logic                 ex_is_in_delayslot,
    output logic                 is_in_delayslot_o
);

    localparam int c_BASE_W = ALUOP_W + ALUSEL_W + 4 * DATA_W + REGADDR_W + 2;
`ifdef ID_EX_EXCEPT_EN
    localparam int c_PAY_W  = c_BASE_W + 32 + DATA_W;
`else
    localparam int c_PAY_W  = c_BASE_W;
`endif

    logic [c_PAY_W-1:0]   w_in_pay;
    logic [c_PAY_W-1:0]   w_out_pay;
    logic                 w_valid;
    logic [ALUOP_W-1:0]   w_aluop;
    logic [ALUSEL_W-1:0]  w_alusel;
    logic [DATA_W-1:0]    w_reg1;
    logic [DATA_W-1:0]    w_reg2;
    logic [REGADDR_W-1:0] w_wd;
    logic                 w_wreg;
    logic [DATA_W-1:0]    w_link_address;
    logic [DATA_W-1:0]    w_inst;
    logic                 w_is_in_ds;
    logic                 r_ds;

`ifdef ID_EX_EXCEPT_EN
    logic [31:0]          w_excepttype;
    logic [DATA_W-1:0]    w_cur_addr;

    assign w_in_pay = {id_excepttype, id_current_inst_address, id_aluop, id_alusel,
                       id_reg1, id_reg2, id_wd, id_wreg, id_link_address, id_inst,
                       id_is_in_delayslot};
    assign {w_excepttype, w_cur_addr, w_aluop, w_alusel, w_reg1, w_reg2, w_wd, w_wreg,
            w_link_address, w_inst, w_is_in_ds} = w_out_pay;
    assign ex_excepttype           = w_valid ? w_excepttype : '0;
    assign ex_current_inst_address = w_valid ? w_cur_addr   : '0;
`else
    assign w_in_pay = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
                       id_link_address, id_inst, id_is_in_delayslot};
    assign {w_aluop, w_alusel, w_reg1, w_reg2, w_wd, w_wreg,
            w_link_address, w_inst, w_is_in_ds} = w_out_pay;
`endif

    pipe_skid_buf #(
        .WIDTH (c_PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (id_valid),
        .in_ready  (id_ready),
        .in_data   (w_in_pay),
        .out_valid (w_valid),
        .out_ready (ex_ready),
        .out_data  (w_out_pay)
    );

    // Bubbles present as NOPs with every field zeroed, so EX never sees stale data.
    assign ex_valid           = w_valid;
    assign ex_aluop           = w_valid ? w_aluop  : ALUOP_W'(c_NOP_ALUOP);
    assign ex_alusel          = w_valid ? w_alusel : ALUSEL_W'(c_NOP_ALUSEL);
    assign ex_reg1            = w_valid ? w_reg1         : '0;
    assign ex_reg2            = w_valid ? w_reg2         : '0;
    assign ex_wd              = w_valid ? w_wd           : '0;
    assign ex_wreg            = w_valid && w_wreg;
    assign ex_link_address    = w_valid ? w_link_address : '0;
    assign ex_inst            = w_valid ? w_inst         : '0;
    assign ex_is_in_delayslot = w_valid && w_is_in_ds;
    assign is_in_delayslot_o  = r_ds;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ds <= 1'b0;
        end else if (id_valid && id_ready) begin
            r_ds <= id_next_inst_in_delayslot;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// ============================================================================
// Module   : tb_id_ex_pipe
// Desc     : Table-driven self-checking bench for id_ex_pipe plus corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg1;
    logic [31:0] id_reg2;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic [31:0] id_link_address;
    logic [31:0] id_inst;
    logic        id_is_in_delayslot;
    logic        id_next_inst_in_delayslot;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_link_address;
    logic [31:0] ex_inst;
    logic        ex_is_in_delayslot;
    logic        is_in_delayslot_o;
`ifdef ID_EX_EXCEPT_EN
    logic [31:0] id_excepttype = '0;
    logic [31:0] id_current_inst_address = '0;
    logic [31:0] ex_excepttype;
    logic [31:0] ex_current_inst_address;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk                       (clk),
        .rst                       (rst),
        .flush                     (flush),
        .id_valid                  (id_valid),
        .id_ready                  (id_ready),
        .id_aluop                  (id_aluop),
        .id_alusel                 (id_alusel),
        .id_reg1                   (id_reg1),
        .id_reg2                   (id_reg2),
        .id_wd                     (id_wd),
        .id_wreg                   (id_wreg),
        .id_link_address           (id_link_address),
        .id_inst                   (id_inst),
        .id_is_in_delayslot        (id_is_in_delayslot),
        .id_next_inst_in_delayslot (id_next_inst_in_delayslot),
`ifdef ID_EX_EXCEPT_EN
        .id_excepttype             (id_excepttype),
        .id_current_inst_address   (id_current_inst_address),
        .ex_excepttype             (ex_excepttype),
        .ex_current_inst_address   (ex_current_inst_address),
`endif
        .ex_valid                  (ex_valid),
        .ex_ready                  (ex_ready),
        .ex_aluop                  (ex_aluop),
        .ex_alusel                 (ex_alusel),
        .ex_reg1                   (ex_reg1),
        .ex_reg2                   (ex_reg2),
        .ex_wd                     (ex_wd),
        .ex_wreg                   (ex_wreg),
        .ex_link_address           (ex_link_address),
        .ex_inst                   (ex_inst),
        .ex_is_in_delayslot        (ex_is_in_delayslot),
        .is_in_delayslot_o         (is_in_delayslot_o)
    );

    typedef struct {
        logic        v;
        logic        rdy;
        logic [31:0] r1;
        logic        nds;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_r1;
        logic        e_ds;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [7:0] aluop_of(input logic [31:0] r1);
        return r1[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rdy, input logic fl,
                         input logic [31:0] r1, input logic nds);
        id_valid                  = v;
        ex_ready                  = rdy;
        flush                     = fl;
        id_reg1                   = r1;
        id_reg2                   = ~r1;
        id_aluop                  = aluop_of(r1);
        id_alusel                 = 3'b101;
        id_wd                     = r1[4:0] | 5'd1;
        id_wreg                   = 1'b1;
        id_link_address           = r1 + 32'd8;
        id_inst                   = {r1[15:0], r1[15:0]};
        id_is_in_delayslot        = 1'b0;
        id_next_inst_in_delayslot = nds;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           v  rdy  r1            nds  e_val e_rdy e_r1          e_ds
        vecs[0]  = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'hA3, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'hB0, 1'b1, 1'b1, 1'b1, 32'hB0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'hB4, 1'b0, 1'b1, 1'b1, 32'hB4, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset id_ready", {31'd0, id_ready}, 32'd1);
        chk("reset ds_o", {31'd0, is_in_delayslot_o}, 32'd0);
        chk("reset ex_reg1", ex_reg1, 32'd0);
        rst = 1'b0;

        // Streaming, backpressure/ordering and delay-slot table.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].rdy, 1'b0, vecs[i].r1, vecs[i].nds);
            tick();
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d ex_reg1", i), ex_reg1, vecs[i].e_r1);
            chk($sformatf("v%0d ds_o", i), {31'd0, is_in_delayslot_o}, {31'd0, vecs[i].e_ds});
            chk($sformatf("v%0d ex_wreg", i), {31'd0, ex_wreg}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d ex_aluop", i), {24'd0, ex_aluop},
                {24'd0, vecs[i].e_valid ? aluop_of(vecs[i].e_r1) : 8'h00});
        end

        // Flush while full with a same-cycle incoming entry.
        drive(1'b1, 1'b0, 1'b0, 32'hC1, 1'b1);
        tick();
        chk("fill id_ready", {31'd0, id_ready}, 32'd0);
        chk("fill ds_o", {31'd0, is_in_delayslot_o}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 32'hEE, 1'b1);
        tick();
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush id_ready", {31'd0, id_ready}, 32'd1);
        chk("flush ds_o", {31'd0, is_in_delayslot_o}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("post-flush ex_valid", {31'd0, ex_valid}, 32'd0);

        // Bubble outputs stay NOP while inputs toggle with id_valid low.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, $urandom, 1'b1);
            id_alusel = 3'($urandom);
            tick();
            chk($sformatf("bubble%0d ex_wreg", i), {31'd0, ex_wreg}, 32'd0);
            chk($sformatf("bubble%0d ex_aluop", i), {24'd0, ex_aluop}, 32'd0);
            chk($sformatf("bubble%0d ex_alusel", i), {29'd0, ex_alusel}, 32'd0);
            chk($sformatf("bubble%0d ex_wd", i), {27'd0, ex_wd}, 32'd0);
        end
        chk("bubble ds_o held", {31'd0, is_in_delayslot_o}, 32'd0);

        // Reset with both entries occupied.
        drive(1'b1, 1'b0, 1'b0, 32'hD1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'hD2, 1'b1);
        tick();
        chk("pre-rst id_ready", {31'd0, id_ready}, 32'd0);
        chk("pre-rst ex_reg1", ex_reg1, 32'hD1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'hD3, 1'b1);
        tick();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst id_ready", {31'd0, id_ready}, 32'd1);
        chk("rst ex_wreg", {31'd0, ex_wreg}, 32'd0);
        chk("rst ex_reg1", ex_reg1, 32'd0);
        chk("rst ds_o", {31'd0, is_in_delayslot_o}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("post-rst ex_valid", {31'd0, ex_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
